// File: rtl/fifo_param_if.sv
// Push/pop bus of one fifo_param channel: producer/consumer side is master, FIFO is slave.
// Latency: none (wires only).
// Backpressure: producer watches full/almost_full; consumer watches empty/valid_out.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] fifo_Data_in;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_Data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output fifo_Data_in, push, pop,
        input  fifo_Data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  fifo_Data_in, push, pop,
        output fifo_Data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost flags, sticky errors.
// Latency: a pushed word is poppable next edge; pop data is registered (1 cycle).
// Backpressure: push on full is dropped (overflow) unless a pop frees a slot in the same cycle.
module fifo_param #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic         clk,
    input  logic         reset_L,
    fifo_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  overflow;
    logic                  underflow;

    logic is_full;
    logic is_empty;
    logic pop_ok;
    logic push_ok;

    // Flags come straight from the registered count, so they never disagree with it.
    assign is_full  = (count == DEPTH_C);
    assign is_empty = (count == '0);

    // A pop needs data; a push needs room, which a same-cycle pop provides even when full.
    // On empty, push+pop accepts only the push: there is no write-to-read bypass.
    assign pop_ok  = bus.pop && !is_empty;
    assign push_ok = bus.push && (!is_full || pop_ok);

    // Storage is not reset; stale contents are never visible because count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.fifo_Data_in;
        end
    end

    // Pointers, occupancy, read register and sticky error flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            valid_out <= pop_ok;
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
            if (bus.push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (bus.pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.fifo_Data_out = data_out;
    assign bus.valid_out     = valid_out;
    assign bus.count         = count;
    assign bus.full          = is_full;
    assign bus.empty         = is_empty;
    assign bus.almost_full   = (count >= AF_C);
    assign bus.almost_empty  = (count <= AE_C);
    assign bus.overflow      = overflow;
    assign bus.underflow     = underflow;
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param against a queue-based reference model.
// Latency: model step at each rising edge, outputs compared 1 time unit later.
// Backpressure: model decides acceptance from its own occupancy, not from DUT flags.
module tb_fifo_param;
    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk;
    logic reset_L;

    fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO contents as a plain queue.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic r, input logic [DW-1:0] d);
        bit pop_ok;
        bit push_ok;
        pop_ok  = r && (mq.size() > 0);
        push_ok = p && ((mq.size() < DEPTH) || pop_ok);
        if (p && !push_ok) m_ovf = 1'b1;
        if (r && !pop_ok)  m_unf = 1'b1;
        m_valid = pop_ok;
        if (pop_ok) m_dout = mq.pop_front();
        if (push_ok) mq.push_back(d);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, " count"},        32'(ifc.count),        32'(n));
        chk({tag, " full"},         32'(ifc.full),         32'(n == DEPTH));
        chk({tag, " empty"},        32'(ifc.empty),        32'(n == 0));
        chk({tag, " almost_full"},  32'(ifc.almost_full),  32'(n >= AF));
        chk({tag, " almost_empty"}, 32'(ifc.almost_empty), 32'(n <= AE));
        chk({tag, " valid_out"},    32'(ifc.valid_out),    32'(m_valid));
        chk({tag, " data_out"},     32'(ifc.fifo_Data_out), 32'(m_dout));
        chk({tag, " overflow"},     32'(ifc.overflow),     32'(m_ovf));
        chk({tag, " underflow"},    32'(ifc.underflow),    32'(m_unf));
    endtask

    task automatic cycle(input string tag, input logic p, input logic r, input logic [DW-1:0] d);
        ifc.push         = p;
        ifc.pop          = r;
        ifc.fifo_Data_in = d;
        @(posedge clk);
        model_step(p, r, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_L          = 1'b1;
        ifc.push         = 1'b1;
        ifc.pop          = 1'b1;
        ifc.fifo_Data_in = 10'h3FF;
        model_reset();
        #2 reset_L = 1'b0;

        // Reset held with push/pop requested: nothing may change.
        repeat (3) @(posedge clk);
        #1 check_all("reset");

        @(negedge clk);
        reset_L  = 1'b1;
        ifc.push = 1'b0;
        ifc.pop  = 1'b0;
        #1;

        // Fill with 1..8.
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 1'b0, 10'(i));
        chk("fill full", 32'(ifc.full), 32'd1);

        // Push on full without pop: dropped.
        cycle("overflow", 1'b1, 1'b0, 10'h3FF);
        chk("overflow flag", 32'(ifc.overflow), 32'd1);

        // Drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle("drain", 1'b0, 1'b1, 10'h000);
            chk("drain order", 32'(ifc.fifo_Data_out), 32'(i));
        end

        // Push+pop on empty: push accepted, pop rejected.
        cycle("empty pp", 1'b1, 1'b1, 10'h155);
        chk("empty pp count", 32'(ifc.count), 32'd1);
        cycle("pop 155", 1'b0, 1'b1, 10'h000);
        chk("pop 155 data", 32'(ifc.fifo_Data_out), 32'h155);

        // Full push+pop across three pointer laps.
        for (int i = 1; i <= DEPTH; i++) cycle("refill", 1'b1, 1'b0, 10'(8'h40 + i));
        cycle("full pp", 1'b1, 1'b1, 10'h2AA);
        for (int i = 1; i <= 3 * DEPTH - 1; i++) begin
            cycle("wrap", 1'b1, 1'b1, 10'(10'h100 + i));
            if (i == DEPTH) chk("wrap 2aa", 32'(ifc.fifo_Data_out), 32'h2AA);
        end

        // Drain to 5, then reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++) cycle("to5", 1'b0, 1'b1, 10'h000);
        chk("count5", 32'(ifc.count), 32'd5);
        #3 reset_L = 1'b0;
        model_reset();
        #1 check_all("async reset");
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        cycle("resume push", 1'b1, 1'b0, 10'h0AB);
        cycle("resume pop", 1'b0, 1'b1, 10'h000);
        chk("resume data", 32'(ifc.fifo_Data_out), 32'h0AB);

        // Randomised traffic with varying push/pop bias to visit full and empty often.
        for (int ph = 0; ph < 4; ph++) begin
            int pb;
            pb = (ph == 0) ? 75 : (ph == 1) ? 25 : (ph == 2) ? 50 : 90;
            for (int k = 0; k < 150; k++) begin
                logic p;
                logic r;
                p = ($urandom_range(0, 99) < pb);
                r = ($urandom_range(0, 99) < (100 - pb + 10));
                cycle("random", p, r, 10'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO that supersedes the bare dual-port memory plus externally driven read/write addresses. It owns its storage array, write/read pointers and an occupancy counter. It exposes a push/pop interface with full/empty, programmable almost-full/almost-empty thresholds and sticky overflow/underflow errors. It sits between a data producer and the downstream arbiter/demux stages of the datapath, one instance per channel.

## Interface

- DATA_WIDTH, 10, word width in bits
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH words (default 8)
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (1..DEPTH-1)
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-2)

- clk  input  1  single clock, all state on rising edge
- reset_L  input  1  asynchronous active-low reset
- fifo_Data_in  input  DATA_WIDTH  write data, sampled with push
- push  input  1  write request
- pop  input  1  read request
- fifo_Data_out  output  DATA_WIDTH  registered read data
- valid_out  output  1  fifo_Data_out holds a word popped on the previous cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

## Operation

- Reset (reset_L low, any time, asynchronous): wr_ptr = rd_ptr = 0, count = 0, fifo_Data_out = 0, valid_out = 0, overflow = underflow = 0, empty = 1, almost_empty = 1, full = almost_full = 0. Memory contents are not cleared and are don't-care. Reset mid-operation discards all stored words.
- Push accepted when push=1 and (full=0 or pop accepted same cycle): mem[wr_ptr] <= fifo_Data_in, wr_ptr += 1 mod DEPTH.
- Pop accepted when pop=1 and empty=0: fifo_Data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr += 1 mod DEPTH. Otherwise valid_out <= 0 and fifo_Data_out holds its last value.
- Count update: +1 for push-only accepted, -1 for pop-only accepted, unchanged for both or neither.
- Simultaneous push+pop when full: both accepted, count stays DEPTH, no overflow.
- Simultaneous push+pop when empty: push accepted, pop rejected (underflow set), count becomes 1. No bypass of the write word to the output.
- Push when full without pop: word dropped, pointers unchanged, overflow <= 1.
- Pop when empty: underflow <= 1, valid_out <= 0.
- overflow/underflow clear only on reset.
- Pointers wrap from DEPTH-1 to 0 with no gap. Full/empty are derived from count, not from pointer equality.
- All flags are decoded from the registered count, so they are glitch-free and consistent with count every cycle.

## Timing

- Write latency: a word pushed at edge N is poppable at edge N+1 (empty deasserts after edge N).
- Read latency: 1 cycle; pop at edge N makes fifo_Data_out/valid_out valid after edge N, for the cycle N..N+1.
- Flags/count change only on clock edges, except on asynchronous assertion of reset_L.
- Back-to-back pops every cycle stream one word per cycle with valid_out held high.
- Reset release is synchronous in effect: the first push can be accepted on the first rising edge with reset_L high.

## Test plan

- Reset: hold reset_L=0 with push=pop=1 -> count=0, empty=1, almost_empty=1, valid_out=0, fifo_Data_out=0, errors 0.
- Fill/drain: push 0x001..0x008 on 8 consecutive cycles -> full=1 and almost_full=1 from count 6, count=8. Then pop 8 cycles -> fifo_Data_out 0x001..0x008 in order with valid_out=1, ending with empty=1.
- Overflow: when full, push 0x3FF -> overflow=1, count=8, the popped sequence excludes 0x3FF. Overflow stays 1 until reset.
- Underflow/simultaneous on empty: push=pop=1 with data 0x155 on empty -> underflow=1, count=1, valid_out=0. Next-cycle pop -> 0x155, valid_out=1.
- Full push+pop: at count=8, push 0x2AA and pop together -> count=8, oldest word out, no overflow. 0x2AA emerges as the 8th subsequent pop (wrap-around checked over 3 full pointer laps).
- Reset mid-operation: count=5, assert reset_L low mid-cycle -> outputs take reset values immediately. After release, push/pop resumes from empty.
